fp16_to_int_conv: RTL and testbench

Streaming converter from IEEE-style fp16 (the format produced by fp16adder: bias 15, hidden 1) to signed fixed-point integer. It unpacks the fp16 fields, which is the inverse of fp16adder's packing. It sits at the output of the TPU accumulate path and feeds quantised results to integer consumers. The datapath is a 2-stage pipeline with valid/ready handshake on both sides, rounding-mode select and saturation.

---
 rtl/fp16_to_int_conv.sv | 150 +++++++++++++++
 tb/tb_fp16_to_int_conv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_int_conv.sv
// fp16 -> signed fixed-point converter, 2-stage valid/ready pipeline, 1 beat/cycle, holds output under backpressure.
// Optional saturation event counter enabled by defining FP2INT_SAT_CNT_EN.
module fp16_to_int_conv #(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_nan,
  output logic [15:0]      sat_count,
  input  logic             sat_clr
);

  // Magnitude work width: must hold 2^OUT_W and an unshifted 11-bit mantissa.
  localparam int MW = (OUT_W + 1 > 12) ? OUT_W + 1 : 12;
  localparam logic [MW-1:0]    POS_MAX = MW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [MW-1:0]    NEG_MAG = MW'(64'd1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] MAX_V   = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V   = {1'b1, {(OUT_W - 1){1'b0}}};

  logic              s1_valid, s1_sign, s1_rnd, s1_zero, s1_inf, s1_nan;
  logic [10:0]       s1_mag;
  logic signed [7:0] s1_e;

  logic out_adv, s1_adv, in_fire;
  logic is_zero, is_max, man_nz;
  logic signed [7:0] e_in;

  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && out_adv;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign is_zero = (in_data[14:10] == 5'd0);
  assign is_max  = &in_data[14:10];
  assign man_nz  = |in_data[9:0];
  assign e_in    = 8'(in_data[14:10]) - 8'd15 + 8'(FRAC_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rnd   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_mag   <= '0;
      s1_e     <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_sign <= in_data[15];
        s1_rnd  <= rnd_mode;
        s1_zero <= is_zero;
        s1_inf  <= is_max && !man_nz;
        s1_nan  <= is_max && man_nz;
        s1_mag  <= {1'b1, in_data[9:0]};
        s1_e    <= e_in;
      end
    end
  end

  logic [7:0]       lsh, rsh;
  logic             big, guard, sticky, inc, ovf;
  logic [10:0]      int11;
  logic [MW-1:0]    mag_int;
  logic [OUT_W-1:0] val_nx;
  logic             sat_nx, nan_nx;

  always_comb begin
    lsh     = 8'(s1_e - 8'sd10);
    rsh     = 8'(8'sd10 - s1_e);
    big     = 1'b0;
    guard   = 1'b0;
    sticky  = 1'b0;
    inc     = 1'b0;
    int11   = '0;
    mag_int = '0;
    if (s1_e >= 8'sd10) begin
      // Range check precedes the shift so an oversized exponent never wraps.
      big     = (32'(lsh) + 32'd10) > 32'(OUT_W - 1);
      mag_int = big ? '0 : (MW'(s1_mag) << lsh);
    end else begin
      if (rsh >= 8'd12) begin
        sticky = 1'b1;
      end else begin
        int11  = s1_mag >> rsh[3:0];
        guard  = |(s1_mag & (11'd1 << (rsh[3:0] - 4'd1)));
        sticky = |(s1_mag & (11'h7FF >> (4'd12 - rsh[3:0])));
      end
      inc     = s1_rnd & guard & (sticky | int11[0]);
      mag_int = MW'(int11) + MW'(inc);
    end
    ovf = big || (s1_sign ? (mag_int > NEG_MAG) : (mag_int > POS_MAX));

    val_nx = '0;
    sat_nx = 1'b0;
    nan_nx = 1'b0;
    if (s1_nan) begin
      nan_nx = 1'b1;
    end else if (!s1_zero) begin
      if (s1_inf || ovf) begin
        sat_nx = 1'b1;
        val_nx = s1_sign ? MIN_V : MAX_V;
      end else begin
        val_nx = s1_sign ? OUT_W'(~mag_int + MW'(1)) : OUT_W'(mag_int);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= val_nx;
        out_sat  <= sat_nx;
        out_nan  <= nan_nx;
      end
    end
  end

`ifdef FP2INT_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_fp16_to_int_conv.sv
// Scoreboard bench for fp16_to_int_conv: FRAC_BITS=0 main instance plus a FRAC_BITS=8 instance.
module tb_fp16_to_int_conv;

  logic        clk, rst_n;
  logic        in_valid, in_ready, rnd_mode, out_valid, out_ready, out_sat, out_nan, sat_clr;
  logic [15:0] in_data, out_data, sat_count;

  logic        f8_in_valid, f8_in_ready, f8_rnd, f8_out_valid, f8_out_ready, f8_out_sat, f8_out_nan, f8_sat_clr;
  logic [15:0] f8_in_data, f8_out_data, f8_sat_count;

  typedef struct {
    string       nm;
    logic [15:0] d;
    logic        s;
    logic        n;
    int          txc;
  } exp_t;

  exp_t exp_q[$];
  exp_t f8_q[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fp16_to_int_conv #(.OUT_W(16), .FRAC_BITS(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_nan(out_nan), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  fp16_to_int_conv #(.OUT_W(16), .FRAC_BITS(8)) dut_f8 (
    .clk(clk), .rst_n(rst_n), .in_valid(f8_in_valid), .in_ready(f8_in_ready), .in_data(f8_in_data),
    .rnd_mode(f8_rnd), .out_valid(f8_out_valid), .out_ready(f8_out_ready), .out_data(f8_out_data),
    .out_sat(f8_out_sat), .out_nan(f8_out_nan), .sat_count(f8_sat_count), .sat_clr(f8_sat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Main-instance monitor: scoreboard pop plus hold-stability under stall.
  logic        held_vld = 1'b0;
  logic [15:0] held_d;
  logic        held_s, held_n;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        chk("hold_data", out_data, held_d);
        chk("hold_sat", out_sat, held_s);
        chk("hold_nan", out_nan, held_n);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_data"}, out_data, e.d);
          chk({e.nm, "_sat"}, out_sat, e.s);
          chk({e.nm, "_nan"}, out_nan, e.n);
          if (e.txc >= 0) chk({e.nm, "_latency"}, cyc - e.txc, 2);
          pop_cyc.push_back(cyc);
        end
      end
      held_vld = out_valid && !out_ready;
      held_d   = out_data;
      held_s   = out_sat;
      held_n   = out_nan;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && f8_out_valid && f8_out_ready) begin
      if (f8_q.size() == 0) begin
        chk("f8_extra_beat", f8_out_valid, 0);
      end else begin
        e = f8_q.pop_front();
        chk({e.nm, "_data"}, f8_out_data, e.d);
        chk({e.nm, "_sat"}, f8_out_sat, e.s);
        chk({e.nm, "_nan"}, f8_out_nan, e.n);
      end
    end
  end

  // txc is the cycle in which the handshake is presented; output is expected two cycles later.
  task automatic send(input string nm, input logic [15:0] d, input logic r, input logic [15:0] ed,
                      input logic es, input logic en, input bit push, input bit lat);
    int   n;
    bit   ok;
    int   txc;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    rnd_mode = r;
    n   = 0;
    ok  = 1'b0;
    txc = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok  = in_ready;
      txc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      chk({nm, "_accept_timeout"}, in_ready, 1);
    end else if (push) begin
      e.nm = nm; e.d = ed; e.s = es; e.n = en; e.txc = lat ? txc : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send8(input string nm, input logic [15:0] d, input logic [15:0] ed, input logic es);
    int   n;
    bit   ok;
    exp_t e;
    f8_in_valid = 1'b1;
    f8_in_data  = d;
    f8_rnd      = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = f8_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    f8_in_valid = 1'b0;
    if (!ok) begin
      chk({nm, "_accept_timeout"}, f8_in_ready, 1);
    end else begin
      e.nm = nm; e.d = ed; e.s = es; e.n = 1'b0; e.txc = -1;
      f8_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || f8_q.size() > 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", exp_q.size() + f8_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rnd_mode = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    f8_in_valid = 1'b0; f8_in_data = '0; f8_rnd = 1'b1; f8_out_ready = 1'b1; f8_sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_nan", out_nan, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic conversion with latency check
    send("one",     16'h3C00, 1, 16'h0001, 0, 0, 1, 1);
    send("neg_one", 16'hBC00, 1, 16'hFFFF, 0, 0, 1, 1);
    send("zero",    16'h0000, 1, 16'h0000, 0, 0, 1, 1);
    send("neg_zero",16'h8000, 1, 16'h0000, 0, 0, 1, 1);
    // Rounding
    send("p1_5_rne", 16'h3E00, 1, 16'h0002, 0, 0, 1, 0);
    send("p1_5_trn", 16'h3E00, 0, 16'h0001, 0, 0, 1, 0);
    send("p2_5_rne", 16'h4100, 1, 16'h0002, 0, 0, 1, 0);
    send("p0_5_rne", 16'h3800, 1, 16'h0000, 0, 0, 1, 0);
    send("p0_75_rne",16'h3A00, 1, 16'h0001, 0, 0, 1, 0);
    send("m1_5_trn", 16'hBE00, 0, 16'hFFFF, 0, 0, 1, 0);
    send("m1_5_rne", 16'hBE00, 1, 16'hFFFE, 0, 0, 1, 0);
    wait_drain();

    // Saturation and specials
    send("p32768", 16'h7800, 1, 16'h7FFF, 1, 0, 1, 0);
    send("m32768", 16'hF800, 1, 16'h8000, 0, 0, 1, 0);
    send("pinf",   16'h7C00, 1, 16'h7FFF, 1, 0, 1, 0);
    send("nan",    16'h7E00, 1, 16'h0000, 0, 1, 1, 0);
    wait_drain();
`ifdef FP2INT_SAT_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    chk("sat_count_after_sat", sat_count, exp_cnt);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_count_clr", sat_count, 0);

    send("ninf",    16'hFC00, 0, 16'h8000, 1, 0, 1, 0);
    send("p65504",  16'h7BFF, 0, 16'h7FFF, 1, 0, 1, 0);
    send("subnorm", 16'h0001, 1, 16'h0000, 0, 0, 1, 0);
    send("third",   16'h3555, 1, 16'h0000, 0, 0, 1, 0);
    wait_drain();

    // Backpressure: six beats, consumer stalled for five cycles
    out_ready = 1'b0;
    pop_cyc.delete();
    fork
      begin
        send("bp1", 16'h3C00, 1, 16'h0001, 0, 0, 1, 0);
        send("bp2", 16'h4000, 1, 16'h0002, 0, 0, 1, 0);
        send("bp3", 16'h4200, 1, 16'h0003, 0, 0, 1, 0);
        send("bp4", 16'h4400, 1, 16'h0004, 0, 0, 1, 0);
        send("bp5", 16'h4500, 1, 16'h0005, 0, 0, 1, 0);
        send("bp6", 16'h4600, 1, 16'h0006, 0, 0, 1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_beat_count", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) chk("bp_throughput", pop_cyc[5] - pop_cyc[0], 5);

    // FRAC_BITS = 8 instance
    send8("f8_one",   16'h3C00, 16'h0100, 0);
    send8("f8_third", 16'h3555, 16'h0055, 0);
    send8("f8_sat",   16'h5BFF, 16'h7FFF, 1);
    send8("f8_neg",   16'hBC00, 16'hFF00, 0);
    wait_drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send("inflight1", 16'h4000, 1, 16'h0002, 0, 0, 0, 0);
    send("inflight2", 16'h4200, 1, 16'h0003, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send("post_rst", 16'h4400, 1, 16'h0004, 0, 0, 1, 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
